// File: rtl/video_apf_out_if.sv
// Signal bundle between the LCD stage and the APF video output block.
// The slave modport is the output block's view; master is the LCD-side driver.
interface video_apf_out_if;
    logic        ce_pix;
    logic        hs;
    logic        vs;
    logic        hbl;
    logic        vbl;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        sgb_en;
    logic [2:0]  scaler_slot;
    logic        err_clr;
    logic [23:0] video_rgb;
    logic        video_de;
    logic        video_skip;
    logic        video_hs;
    logic        video_vs;
    logic        width_err;
    logic        height_err;
    logic [15:0] frame_cnt;

    modport slave (
        input  ce_pix, hs, vs, hbl, vbl, r, g, b, sgb_en, scaler_slot, err_clr,
        output video_rgb, video_de, video_skip, video_hs, video_vs,
               width_err, height_err, frame_cnt
    );

    modport master (
        output ce_pix, hs, vs, hbl, vbl, r, g, b, sgb_en, scaler_slot, err_clr,
        input  video_rgb, video_de, video_skip, video_hs, video_vs,
               width_err, height_err, frame_cnt
    );
endinterface

// File: rtl/video_apf_out.sv
// Re-times LCD-stage video into the APF output format: one input register stage,
// one output register stage, sync pulses, end-of-line control word and geometry checks.
module video_apf_out #(
    parameter int W_GB  = 160,
    parameter int W_SGB = 256,
    parameter int H_GB  = 144,
    parameter int H_SGB = 224
) (
    input  logic           clk_vid,
    input  logic           reset_n,
    video_apf_out_if.slave vid
);
    localparam logic [8:0] WGB  = 9'(W_GB);
    localparam logic [8:0] WSGB = 9'(W_SGB);
    localparam logic [8:0] HGB  = 9'(H_GB);
    localparam logic [8:0] HSGB = 9'(H_SGB);

    logic        s1Ce_q, s1Hs_q, s1Vs_q, s1De_q, s1Sgb_q, s1Clr_q;
    logic [23:0] s1Rgb_q;
    logic [2:0]  s1Slot_q;

    logic        primed_q, hsPrev_q, vsPrev_q, dePrev_q;
    logic        hsPend_q, lineValid_q, frameValid_q, sgbW_q, sgbH_q;
    logic [8:0]  pixCnt_q, lineCnt_q;
    logic [8:0]  pixCnt_d, lineCnt_d;

    logic        videoDe_q, videoSkip_q, videoHs_q, videoVs_q;
    logic        widthErr_q, heightErr_q;
    logic [23:0] videoRgb_q;
    logic [15:0] frameCnt_q;
    logic        videoDe_d, videoSkip_d;
    logic [23:0] videoRgb_d;

    logic        edgeCe, hsRise, vsRise, deRise, deFall, widthEvt, heightEvt;
    logic [8:0]  expW, expH;

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            s1Ce_q   <= 1'b0;
            s1Hs_q   <= 1'b0;
            s1Vs_q   <= 1'b0;
            s1De_q   <= 1'b0;
            s1Sgb_q  <= 1'b0;
            s1Clr_q  <= 1'b0;
            s1Rgb_q  <= '0;
            s1Slot_q <= '0;
        end else begin
            s1Ce_q   <= vid.ce_pix;
            s1Hs_q   <= vid.hs;
            s1Vs_q   <= vid.vs;
            s1De_q   <= ~vid.hbl & ~vid.vbl;
            s1Sgb_q  <= vid.sgb_en;
            s1Clr_q  <= vid.err_clr;
            s1Rgb_q  <= {vid.r, vid.g, vid.b};
            s1Slot_q <= vid.scaler_slot;
        end
    end

    // Edges only count once the history holds a real sample, so levels already
    // high when reset releases never look like rising edges.
    always_comb begin
        edgeCe    = s1Ce_q & primed_q;
        hsRise    = edgeCe & s1Hs_q & ~hsPrev_q;
        vsRise    = edgeCe & s1Vs_q & ~vsPrev_q;
        deRise    = edgeCe & s1De_q & ~dePrev_q;
        deFall    = edgeCe & ~s1De_q & dePrev_q;
        expW      = sgbW_q ? WSGB : WGB;
        expH      = sgbH_q ? HSGB : HGB;
        widthEvt  = deFall & lineValid_q & (pixCnt_q != expW);
        heightEvt = vsRise & (lineCnt_q != 9'd0) & (lineCnt_q != expH);
    end

    always_comb begin
        pixCnt_d = pixCnt_q;
        if (deRise)
            pixCnt_d = 9'd1;
        else if (s1Ce_q & s1De_q & (pixCnt_q != '1))
            pixCnt_d = pixCnt_q + 9'd1;

        lineCnt_d = lineCnt_q;
        if (vsRise)
            lineCnt_d = 9'd0;
        else if (deFall & frameValid_q & (lineCnt_q != '1))
            lineCnt_d = lineCnt_q + 9'd1;
    end

    // Outside the active region the word is zero, except the slot marker in the
    // first blank cycle; skipped cycles keep the last pixel on the bus.
    always_comb begin
        videoDe_d   = s1Ce_q ? s1De_q : videoDe_q;
        videoSkip_d = videoDe_d & ~s1Ce_q;
        if (videoDe_d)
            videoRgb_d = s1Ce_q ? s1Rgb_q : videoRgb_q;
        else if (videoDe_q)
            videoRgb_d = {13'b0, s1Slot_q, 8'b0};
        else
            videoRgb_d = '0;
    end

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            primed_q     <= 1'b0;
            hsPrev_q     <= 1'b0;
            vsPrev_q     <= 1'b0;
            dePrev_q     <= 1'b0;
            hsPend_q     <= 1'b0;
            lineValid_q  <= 1'b0;
            frameValid_q <= 1'b0;
            sgbW_q       <= 1'b0;
            sgbH_q       <= 1'b0;
            pixCnt_q     <= '0;
            lineCnt_q    <= '0;
            videoDe_q    <= 1'b0;
            videoSkip_q  <= 1'b0;
            videoHs_q    <= 1'b0;
            videoVs_q    <= 1'b0;
            videoRgb_q   <= '0;
            widthErr_q   <= 1'b0;
            heightErr_q  <= 1'b0;
            frameCnt_q   <= '0;
        end else begin
            if (s1Ce_q) begin
                primed_q <= 1'b1;
                hsPrev_q <= s1Hs_q;
                vsPrev_q <= s1Vs_q;
                dePrev_q <= s1De_q;
            end
            if (deRise) begin
                lineValid_q <= 1'b1;
                sgbW_q      <= s1Sgb_q;
            end else if (deFall) begin
                lineValid_q <= 1'b0;
            end
            if (vsRise) begin
                frameValid_q <= 1'b1;
                sgbH_q       <= s1Sgb_q;
            end
            pixCnt_q    <= pixCnt_d;
            lineCnt_q   <= lineCnt_d;
            // A coincident hs edge is deferred one cycle so the vs pulse leads.
            hsPend_q    <= hsRise & vsRise;
            videoHs_q   <= (hsRise & ~vsRise) | hsPend_q;
            videoVs_q   <= vsRise;
            frameCnt_q  <= frameCnt_q + {15'b0, vsRise};
            videoDe_q   <= videoDe_d;
            videoSkip_q <= videoSkip_d;
            videoRgb_q  <= videoRgb_d;
            widthErr_q  <= s1Clr_q ? 1'b0 : (widthErr_q | widthEvt);
            heightErr_q <= s1Clr_q ? 1'b0 : (heightErr_q | heightEvt);
        end
    end

    assign vid.video_rgb  = videoRgb_q;
    assign vid.video_de   = videoDe_q;
    assign vid.video_skip = videoSkip_q;
    assign vid.video_hs   = videoHs_q;
    assign vid.video_vs   = videoVs_q;
    assign vid.width_err  = widthErr_q;
    assign vid.height_err = heightErr_q;
    assign vid.frame_cnt  = frameCnt_q;
endmodule

// File: tb/tb_video_apf_out.sv
// Randomized bench for video_apf_out: a line/frame-level reference model queues the
// expected pixels, control words and sync pulses, and a monitor checks them as they appear.
module tb_video_apf_out;
    localparam int TW_GB  = 16;
    localparam int TW_SGB = 24;
    localparam int TH_GB  = 6;
    localparam int TH_SGB = 8;
    localparam int K_PIX  = 0;
    localparam int K_EOL  = 1;

    typedef struct {
        int          kind;
        int          cyc;
        logic [23:0] data;
    } evt_t;

    logic clk_vid = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   nChecks = 0;
    int   nErrors = 0;

    video_apf_out_if vid();

    video_apf_out #(
        .W_GB (TW_GB),
        .W_SGB(TW_SGB),
        .H_GB (TH_GB),
        .H_SGB(TH_SGB)
    ) dut (
        .clk_vid(clk_vid),
        .reset_n(reset_n),
        .vid    (vid)
    );

    always #5 clk_vid = ~clk_vid;
    always @(posedge clk_vid) cyc <= cyc + 1;

    evt_t pixQ[$];
    int   lenQ[$];
    int   vsQ[$];
    int   hsQ[$];

    bit          mPrimed, mHs, mVs, mOutDe, mFrameOpen, mFrameSgb, mWerr, mHerr;
    int          mDeStart, mLines;
    logic [15:0] mFrames;
    bit          inVblank, sgb;

    function automatic int expW(input bit s);
        return s ? TW_SGB : TW_GB;
    endfunction

    function automatic int expH(input bit s);
        return s ? TH_SGB : TH_GB;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic resetModel();
        mPrimed = 0; mHs = 0; mVs = 0; mOutDe = 0; mFrameOpen = 0; mFrameSgb = 0;
        mWerr = 0; mHerr = 0; mDeStart = 0; mLines = 0; mFrames = '0;
        pixQ.delete(); lenQ.delete(); vsQ.delete(); hsQ.delete();
    endtask

    // Drives one clk_vid cycle of LCD-stage inputs and records what must come out two cycles later.
    task automatic applyStimulus(input bit ceIn, input bit hsIn, input bit vsIn, input bit deIn,
                                 input logic [23:0] rgbIn);
        bit   vsR, hsR;
        evt_t e;
        vid.ce_pix = ceIn;
        vid.hs     = hsIn;
        vid.vs     = vsIn;
        vid.hbl    = ~deIn;
        vid.vbl    = inVblank;
        vid.r      = rgbIn[23:16];
        vid.g      = rgbIn[15:8];
        vid.b      = rgbIn[7:0];
        vid.sgb_en = sgb;
        if (ceIn) begin
            if (deIn) begin
                if (!mOutDe) mDeStart = cyc;
                e.kind = K_PIX; e.cyc = cyc + 2; e.data = rgbIn;
                pixQ.push_back(e);
            end else if (mOutDe) begin
                e.kind = K_EOL; e.cyc = cyc + 2; e.data = {13'b0, vid.scaler_slot, 8'b0};
                pixQ.push_back(e);
                lenQ.push_back(cyc - mDeStart);
            end
            mOutDe = deIn;
            if (mPrimed) begin
                vsR = vsIn && !mVs;
                hsR = hsIn && !mHs;
                if (vsR) begin
                    vsQ.push_back(cyc + 2);
                    mFrames++;
                    if (mFrameOpen && mLines != 0 && mLines != expH(mFrameSgb)) mHerr = 1;
                    mFrameOpen = 1;
                    mLines     = 0;
                    mFrameSgb  = sgb;
                end
                if (hsR) hsQ.push_back(vsR ? cyc + 3 : cyc + 2);
            end
            mPrimed = 1;
            mHs     = hsIn;
            mVs     = vsIn;
        end
        @(posedge clk_vid);
        #1;
    endtask

    task automatic sendCe(input bit hsIn, input bit vsIn, input bit deIn,
                          input logic [23:0] rgbIn, input int period);
        applyStimulus(1'b1, hsIn, vsIn, deIn, rgbIn);
        for (int i = 1; i < period; i++)
            applyStimulus(1'b0, hsIn, vsIn, deIn, 24'($urandom));
    endtask

    task automatic sendLine(input int nPix, input int period);
        for (int i = 0; i < nPix; i++) sendCe(1'b0, 1'b0, 1'b1, 24'($urandom), period);
        sendCe(1'b0, 1'b0, 1'b0, 24'h0, period);
        sendCe(1'b1, 1'b0, 1'b0, 24'h0, period);
        sendCe(1'b1, 1'b0, 1'b0, 24'h0, period);
        sendCe(1'b0, 1'b0, 1'b0, 24'h0, period);
        if (nPix != expW(sgb)) mWerr = 1;
        if (mFrameOpen) mLines++;
    endtask

    task automatic sendVblank(input int period);
        inVblank = 1;
        sendCe(1'b0, 1'b0, 1'b0, 24'h0, period);
        sendCe(1'b0, 1'b0, 1'b0, 24'h0, period);
        sendCe(1'b0, 1'b1, 1'b0, 24'h0, period);
        sendCe(1'b0, 1'b1, 1'b0, 24'h0, period);
        sendCe(1'b0, 1'b0, 1'b0, 24'h0, period);
        sendCe(1'b0, 1'b0, 1'b0, 24'h0, period);
        inVblank = 0;
    endtask

    task automatic sendFrame(input int nLines, input int nPix, input int period);
        for (int l = 0; l < nLines; l++) sendLine(nPix, period);
        sendVblank(period);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_width_err"},  32'(vid.width_err),  32'(mWerr));
        checkOutput({tag, "_height_err"}, 32'(vid.height_err), 32'(mHerr));
        checkOutput({tag, "_frame_cnt"},  32'(vid.frame_cnt),  32'(mFrames));
    endtask

    task automatic pulseErrClr(input string tag);
        vid.err_clr = 1'b1;
        applyStimulus(1'b0, mHs, mVs, 1'b0, 24'h0);
        vid.err_clr = 1'b0;
        mWerr = 0;
        mHerr = 0;
        applyStimulus(1'b0, mHs, mVs, 1'b0, 24'h0);
        checkOutput({tag, "_clr_width"},  32'(vid.width_err),  32'(mWerr));
        checkOutput({tag, "_clr_height"}, 32'(vid.height_err), 32'(mHerr));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rgb"},    32'(vid.video_rgb),  32'h0);
        checkOutput({tag, "_de"},     32'(vid.video_de),   32'h0);
        checkOutput({tag, "_skip"},   32'(vid.video_skip), 32'h0);
        checkOutput({tag, "_hs"},     32'(vid.video_hs),   32'h0);
        checkOutput({tag, "_vs"},     32'(vid.video_vs),   32'h0);
        checkOutput({tag, "_werr"},   32'(vid.width_err),  32'h0);
        checkOutput({tag, "_herr"},   32'(vid.height_err), 32'h0);
        checkOutput({tag, "_frames"}, 32'(vid.frame_cnt),  32'h0);
    endtask

    bit monPrevDe = 0;
    int deLen = 0;

    always @(negedge clk_vid) begin : monitor
        evt_t e;
        int   expLen;
        if (!reset_n) begin
            monPrevDe = 0;
            deLen     = 0;
        end else begin
            nChecks++;
            if (vid.video_skip && !vid.video_de) begin
                nErrors++;
                $display("[TB] FAIL skip_outside_de: skip=1 de=0, expected skip=0 (cycle %0d)", cyc);
            end
            if (vid.video_de && !vid.video_skip) begin
                nChecks++;
                if (pixQ.size() == 0) begin
                    nErrors++;
                    $display("[TB] FAIL pixel_unexpected: got rgb %06h, expected no pixel (cycle %0d)", vid.video_rgb, cyc);
                end else begin
                    e = pixQ.pop_front();
                    if (e.kind != K_PIX || e.cyc != cyc || e.data !== vid.video_rgb) begin
                        nErrors++;
                        $display("[TB] FAIL pixel: got rgb %06h at cycle %0d, expected kind %0d rgb %06h at cycle %0d",
                                 vid.video_rgb, cyc, e.kind, e.data, e.cyc);
                    end
                end
            end
            if (monPrevDe && !vid.video_de) begin
                nChecks++;
                if (pixQ.size() == 0) begin
                    nErrors++;
                    $display("[TB] FAIL eol_unexpected: got rgb %06h, expected no line end (cycle %0d)", vid.video_rgb, cyc);
                end else begin
                    e = pixQ.pop_front();
                    if (e.kind != K_EOL || e.cyc != cyc || e.data !== vid.video_rgb) begin
                        nErrors++;
                        $display("[TB] FAIL eol_word: got rgb %06h at cycle %0d, expected kind %0d rgb %06h at cycle %0d",
                                 vid.video_rgb, cyc, e.kind, e.data, e.cyc);
                    end
                end
                nChecks++;
                expLen = (lenQ.size() != 0) ? lenQ.pop_front() : -1;
                if (expLen != deLen) begin
                    nErrors++;
                    $display("[TB] FAIL de_length: got %0d cycles, expected %0d (cycle %0d)", deLen, expLen, cyc);
                end
            end else if (!vid.video_de) begin
                nChecks++;
                if (vid.video_rgb !== 24'h0) begin
                    nErrors++;
                    $display("[TB] FAIL blank_rgb: got %06h, expected 000000 (cycle %0d)", vid.video_rgb, cyc);
                end
            end
            if (vid.video_vs) begin
                nChecks++;
                if (vsQ.size() == 0 || vsQ[0] != cyc) begin
                    nErrors++;
                    $display("[TB] FAIL vs_pulse: got pulse at cycle %0d, expected at %0d", cyc,
                             (vsQ.size() != 0) ? vsQ[0] : -1);
                end
                if (vsQ.size() != 0) void'(vsQ.pop_front());
            end
            if (vid.video_hs) begin
                nChecks++;
                if (hsQ.size() == 0 || hsQ[0] != cyc) begin
                    nErrors++;
                    $display("[TB] FAIL hs_pulse: got pulse at cycle %0d, expected at %0d", cyc,
                             (hsQ.size() != 0) ? hsQ[0] : -1);
                end
                if (hsQ.size() != 0) void'(hsQ.pop_front());
            end
            deLen     = vid.video_de ? (monPrevDe ? deLen + 1 : 1) : 0;
            monPrevDe = vid.video_de;
        end
    end

    initial begin
        int p;
        vid.ce_pix = 0; vid.hs = 0; vid.vs = 0; vid.hbl = 1; vid.vbl = 1;
        vid.r = 0; vid.g = 0; vid.b = 0; vid.sgb_en = 0; vid.scaler_slot = 3'd5; vid.err_clr = 0;
        inVblank = 0;
        sgb      = 0;
        resetModel();
        repeat (3) @(posedge clk_vid);
        #1;
        checkAllZero("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 3; i++) sendCe(1'b0, 1'b0, 1'b0, 24'h0, 1);
        sendVblank(10);

        // Plain GB frame at the nominal ce_pix rate, slot 5 in the line-end word.
        sendFrame(TH_GB, TW_GB, 10);
        checkState("gb_frame");

        for (int f = 0; f < 3; f++) begin
            sgb             = 1'($urandom);
            vid.scaler_slot = 3'($urandom);
            p               = $urandom_range(1, 3);
            sendVblank(p);
            sendFrame(expH(sgb), expW(sgb), p);
            checkState("rand_frame");
        end

        sgb             = 0;
        vid.scaler_slot = 3'd5;
        sendVblank(2);
        sendLine(TW_GB - 1, 2);
        checkOutput("short_line_werr", 32'(vid.width_err), 32'(mWerr));
        pulseErrClr("short_line");
        for (int l = 1; l < TH_GB; l++) sendLine(TW_GB, 2);
        sendVblank(2);
        checkState("after_short");

        sgb = 1;
        sendVblank(3);
        sendFrame(TH_SGB, TW_SGB, 3);
        checkState("sgb_ok");
        sgb = 0;
        sendVblank(3);
        sendFrame(TH_SGB, TW_SGB, 1);
        checkState("sgb_geom_gb_mode");
        pulseErrClr("sgb_geom");

        // hs and vs rising on the same ce_pix cycle.
        inVblank = 1;
        sendCe(1'b0, 1'b0, 1'b0, 24'h0, 1);
        sendCe(1'b0, 1'b0, 1'b0, 24'h0, 1);
        for (int i = 0; i < 3; i++) sendCe(1'b1, 1'b1, 1'b0, 24'h0, 1);
        sendCe(1'b0, 1'b0, 1'b0, 24'h0, 1);
        sendCe(1'b0, 1'b0, 1'b0, 24'h0, 1);
        inVblank = 0;
        sendFrame(TH_GB, TW_GB, 1);
        checkState("coincident");

        // Reset in the middle of a line while vs goes high.
        sendLine(TW_GB, 2);
        for (int i = 0; i < 5; i++) sendCe(1'b0, 1'b0, 1'b1, 24'($urandom), 2);
        vid.vs  = 1'b1;
        reset_n = 1'b0;
        resetModel();
        #1;
        checkAllZero("midline_reset");
        repeat (3) @(posedge clk_vid);
        #1;
        reset_n = 1'b1;
        for (int i = 5; i < TW_GB; i++) sendCe(1'b0, 1'b1, 1'b1, 24'($urandom), 2);
        for (int i = 0; i < 3; i++) sendCe(1'b0, 1'b1, 1'b0, 24'h0, 2);
        checkOutput("post_reset_werr", 32'(vid.width_err), 32'h0);
        checkOutput("post_reset_frames", 32'(vid.frame_cnt), 32'h0);
        inVblank = 1;
        sendCe(1'b0, 1'b0, 1'b0, 24'h0, 2);
        sendCe(1'b0, 1'b0, 1'b0, 24'h0, 2);
        inVblank = 0;
        sendVblank(2);
        checkOutput("first_vs_after_reset", 32'(vid.frame_cnt), 32'h1);
        sendFrame(TH_GB, TW_GB, 2);
        checkState("post_reset_frame");

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        checkOutput("pixel_queue_drained", 32'(pixQ.size()), 32'h0);
        checkOutput("vs_queue_drained",    32'(vsQ.size()),  32'h0);
        checkOutput("hs_queue_drained",    32'(hsQ.size()),  32'h0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule

// File: doc/video_apf_out.md
VIDEO_APF_OUT -- requirements
Module: video_apf_out

Interface
REQ-001 Parameters: W_GB, default 160, active pixels per line in GB mode; W_SGB, default 256, active pixels per line with SGB border; H_GB, default 144, active lines in GB mode; H_SGB, default 224, active lines with SGB border.
REQ-002 clk_vid  in  1  video clock, 67.108864 MHz; only clock in the block.
REQ-003 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 ce_pix  in  1  pixel enable from LCD stage.
REQ-005 hs, vs  in  1 each  level syncs from LCD stage, active-high.
REQ-006 hbl, vbl  in  1 each  blanking levels from LCD stage, active-high.
REQ-007 r, g, b  in  8 each  pixel colour from LCD stage.
REQ-008 sgb_en  in  1  selects W_SGB/H_SGB as expected geometry, else W_GB/H_GB.
REQ-009 scaler_slot  in  3  scaler slot index, placed in end-of-line word.
REQ-010 err_clr  in  1  synchronous clear of error flags.
REQ-011 video_rgb  out  24  {r,g,b} pixel, or control word during blanking.
REQ-012 video_de  out  1  active pixel region.
REQ-013 video_skip  out  1  video_rgb invalid this cycle, within video_de.
REQ-014 video_hs, video_vs  out  1 each  single-cycle sync pulses.
REQ-015 width_err, height_err  out  1 each  sticky geometry error flags.
REQ-016 frame_cnt  out  16  completed-frame counter.

Function
REQ-017 All inputs are registered once (stage S1) on every clk_vid edge; all outputs are registered from S1 (total latency 2 clk_vid cycles, input to output).
REQ-018 Edge detection for hs, vs, and de_in = ~hbl & ~vbl uses previous values latched only on ce_pix cycles in S1.
REQ-019 video_vs = 1 for exactly one cycle, in the cycle after the S1 ce_pix cycle where vs was seen rising; 0 otherwise.
REQ-020 video_hs = 1 for exactly one cycle, in the cycle after the S1 ce_pix cycle where hs was seen rising; if hs and vs rise in the same ce_pix cycle, video_vs pulses that cycle and video_hs pulses one cycle later.
REQ-021 video_de = S1 de_in, held constant between ce_pix cycles.
REQ-022 video_skip = video_de & ~(S1 ce_pix); video_skip = 0 whenever video_de = 0.
REQ-023 video_rgb = S1 {r,g,b} when video_de = 1 and video_skip = 0; value while video_skip = 1 is don't-care but held stable.
REQ-024 Cycle immediately after video_de falls: video_rgb = {13'b0, scaler_slot, 8'b0} for exactly one cycle; all other blanking cycles video_rgb = 24'h000000.
REQ-025 Pixel counter (9 bits) increments on each S1 ce_pix cycle with de_in = 1, cleared on de_in rising edge; saturates at 511.
REQ-026 On de_in falling edge, if pixel count != expected width, width_err <= 1.
REQ-027 Line counter (9 bits) increments on each de_in falling edge, cleared on vs rising edge; saturates at 511.
REQ-028 On vs rising edge, if line counter != 0 and != expected height, height_err <= 1; a first frame with line counter 0 (after reset or LCD off) raises no error.
REQ-029 frame_cnt increments on each video_vs pulse, wraps 65535 -> 0.
REQ-030 err_clr = 1 clears width_err and height_err next edge; if an error event coincides, clear wins.
REQ-031 sgb_en sampled at de_in rising edge (width) and vs rising edge (height); mid-line changes do not affect the current comparison.

Reset
REQ-032 reset_n = 0 asynchronously forces: video_rgb = 0, video_de = 0, video_skip = 0, video_hs = 0, video_vs = 0, width_err = 0, height_err = 0, frame_cnt = 0, all counters and edge-history registers = 0.
REQ-033 After reset release, no sync pulse is emitted for a sync already high; only a subsequent rising edge produces a pulse.
REQ-034 Reset asserted mid-line discards the partial line; no width_err results from it.

Verification
REQ-035 GB frame, sgb_en=0, ce_pix every 10 cycles, 160x144 active -> video_de high 1600 cycles/line, 160 non-skip pixels/line, width_err=height_err=0, frame_cnt +1 per frame.
REQ-036 End of active line, scaler_slot=3'd5 -> video_rgb=24'h000500 for one cycle after video_de falls, then 24'h000000.
REQ-037 Line with 159 active pixels, sgb_en=0 -> width_err=1 after de falls; err_clr pulse -> width_err=0 next cycle.
REQ-038 sgb_en=1, 256x224 frame -> no errors; same frame with sgb_en=0 -> width_err=1 and height_err=1.
REQ-039 hs and vs rise in same ce_pix cycle -> video_vs pulse at cycle T, video_hs pulse at T+1, each exactly one cycle wide.
REQ-040 reset_n pulsed low mid-line with vs high -> all outputs 0 immediately, no video_vs pulse until vs falls and rises again, frame_cnt=0.
